// File: rtl/ray_pkg.sv
// ray_pkg: shared face/shade constants and the buffered pixel entry
// layout for the ray result shading path.
package ray_pkg;

  localparam logic [2:0] FACE_X = 3'b001;
  localparam logic [2:0] FACE_Y = 3'b010;
  localparam logic [2:0] FACE_Z = 3'b100;

  localparam logic [7:0] SHADE_SKY      = 8'hC0;
  localparam logic [7:0] SHADE_TIMEOUT  = 8'h00;
  localparam logic [7:0] SHADE_BAD_FACE = 8'h40;
  localparam logic [7:0] SHADE_FLOOR    = 8'h10;
  localparam logic [7:0] SHADE_FACE_X   = 8'hF0;
  localparam logic [7:0] SHADE_FACE_Y   = 8'hB0;
  localparam logic [7:0] SHADE_FACE_Z   = 8'h70;

  // Coordinates are stored at a fixed width; resolutions up to 1024.
  localparam int COORD_W = 10;

  typedef struct packed {
    logic [7:0]         shade;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_entry_t;

endpackage

// File: rtl/ray_result_shader_if.sv
// ray_result_shader_if: pixel output valid/ready bundle.
// master drives pixels, slave is the pixel output stage.
interface ray_result_shader_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_shade;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;

  modport master (
    output pix_valid, pix_shade, pix_x, pix_y,
    output pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_shade, pix_x, pix_y,
    input  pix_sof, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO; a push while full is accepted
// when a pop happens in the same cycle.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic                   pop_ok,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign pop_ok = w_pop;
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ray_result_shader.sv
// ray_result_shader: shades DDA results, tags pixel coords, buffers them.
// Define RAY_SHADE_ATTEN_EN to enable step-count distance attenuation.
module ray_result_shader
  import ray_pkg::*;
#(
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int H_RES            = 32,
  parameter int V_RES            = 32,
  parameter int DEPTH            = 4,
  parameter int ATTEN_SHIFT      = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        done,
  input  logic                        hit,
  input  logic                        timeout,
  input  logic [2:0]                  face_id,
  input  logic [STEP_COUNT_WIDTH-1:0] steps_taken,
  ray_result_shader_if.master         pix,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        overflow
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [XW-1:0] XMAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] YMAX = YW'(V_RES - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_ovf;
  logic [7:0]    w_base;
  logic [7:0]    w_hit_shade;
  logic [7:0]    w_shade;
  logic          w_face_ok;
  logic          w_full;
  logic          w_empty;
  logic          w_pop_ok;
  logic          w_pop;
  pix_entry_t    w_wr;
  pix_entry_t    w_head;
  logic          w_unused_hi;

  always_comb begin
    w_face_ok = 1'b1;
    w_base    = SHADE_BAD_FACE;
    case (face_id)
      FACE_X:  w_base = SHADE_FACE_X;
      FACE_Y:  w_base = SHADE_FACE_Y;
      FACE_Z:  w_base = SHADE_FACE_Z;
      default: w_face_ok = 1'b0;
    endcase
  end

`ifdef RAY_SHADE_ATTEN_EN
  localparam int AWD = (STEP_COUNT_WIDTH > 8) ? STEP_COUNT_WIDTH : 8;
  logic [AWD-1:0] w_atten;
  logic [AWD-1:0] w_room;
  logic [7:0]     w_sub;

  // Clamp the subtraction so the shade bottoms out at SHADE_FLOOR.
  always_comb begin
    w_atten     = AWD'(steps_taken >> ATTEN_SHIFT);
    w_room      = AWD'(w_base - SHADE_FLOOR);
    w_sub       = (w_atten < w_room) ? w_atten[7:0] : w_room[7:0];
    w_hit_shade = w_base - w_sub;
  end
`else
  logic w_unused_steps;
  assign w_unused_steps = (^steps_taken) ^ (ATTEN_SHIFT != 0);
  assign w_hit_shade    = w_base;
`endif

  always_comb begin
    w_shade = w_hit_shade;
    if (timeout)         w_shade = SHADE_TIMEOUT;
    else if (!hit)       w_shade = SHADE_SKY;
    else if (!w_face_ok) w_shade = SHADE_BAD_FACE;
  end

  always_comb begin
    w_wr.shade = w_shade;
    w_wr.x     = COORD_W'(r_x);
    w_wr.y     = COORD_W'(r_y);
  end

  assign w_pop = pix.pix_valid && pix.pix_ready;

  result_fifo #(
    .WIDTH ($bits(pix_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clock),
    .rst    (reset),
    .push   (done),
    .pop    (w_pop),
    .wdata  (w_wr),
    .rdata  (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .pop_ok (w_pop_ok),
    .count  (fifo_count)
  );

  // Coordinates advance on every result, even dropped ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (done) begin
        if (r_x == XMAX) begin
          r_x <= '0;
          r_y <= (r_y == YMAX) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      if (done && w_full && !w_pop_ok) r_ovf <= 1'b1;
    end
  end

  assign overflow      = r_ovf;
  assign pix.pix_valid = !w_empty;
  assign pix.pix_shade = w_empty ? 8'h00 : w_head.shade;
  assign pix.pix_x     = w_empty ? '0 : w_head.x[XW-1:0];
  assign pix.pix_y     = w_empty ? '0 : w_head.y[YW-1:0];
  assign pix.pix_sof   = !w_empty && (w_head.x[XW-1:0] == '0)
                         && (w_head.y[YW-1:0] == '0);
  assign pix.pix_eol   = !w_empty && (w_head.x[XW-1:0] == XMAX);
  assign w_unused_hi   = ^{w_head.x, w_head.y};
endmodule

// File: tb/tb_ray_result_shader.sv
// Scoreboard bench for ray_result_shader on a 4x4 frame, depth-4 FIFO.
// Expected shades follow RAY_SHADE_ATTEN_EN when it is defined.
module tb_ray_result_shader;
  localparam int HR = 4;
  localparam int VR = 4;
  localparam int DP = 4;
  localparam int SW = 16;
  localparam int XW = $clog2(HR);
  localparam int YW = $clog2(VR);

`ifdef RAY_SHADE_ATTEN_EN
  localparam logic [7:0] E_X40   = 8'hE6;
  localparam logic [7:0] E_X2000 = 8'h10;
  localparam logic [7:0] E_Y100  = 8'h97;
`else
  localparam logic [7:0] E_X40   = 8'hF0;
  localparam logic [7:0] E_X2000 = 8'hF0;
  localparam logic [7:0] E_Y100  = 8'hB0;
`endif

  typedef struct {
    logic [7:0] s;
    int         x;
    int         y;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             done = 1'b0;
  logic             hit = 1'b0;
  logic             timeout = 1'b0;
  logic [2:0]       face_id = 3'b000;
  logic [SW-1:0]    steps_taken = '0;
  logic [$clog2(DP):0] fifo_count;
  logic             overflow;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   mx = 0;
  int   my = 0;

  ray_result_shader_if #(.XW(XW), .YW(YW)) pix ();

  ray_result_shader #(
    .STEP_COUNT_WIDTH (SW),
    .H_RES            (HR),
    .V_RES            (VR),
    .DEPTH            (DP),
    .ATTEN_SHIFT      (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .done        (done),
    .hit         (hit),
    .timeout     (timeout),
    .face_id     (face_id),
    .steps_taken (steps_taken),
    .pix         (pix),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(bit h, bit t, logic [2:0] f, int st,
                      logic [7:0] es, bit accept);
    exp_t x;
    hit         = h;
    timeout     = t;
    face_id     = f;
    steps_taken = st[SW-1:0];
    done        = 1'b1;
    x.s = es;
    x.x = mx;
    x.y = my;
    if (accept) q.push_back(x);
    if (mx == HR-1) begin
      mx = 0;
      my = (my == VR-1) ? 0 : my + 1;
    end else begin
      mx++;
    end
    @(posedge clock);
    #1 done = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    pix.pix_ready = 1'b1;
    while ((q.size() != 0 || pix.pix_valid) && k < 50) begin
      @(posedge clock);
      #1 k++;
    end
    n_vec++;
    if (k >= 50) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d left expected 0", q.size());
    end
  endtask

  always @(negedge clock) begin
    if (!reset && pix.pix_valid && pix.pix_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pixel: got shade %0h expected none",
                 pix.pix_shade);
      end else begin
        e = q.pop_front();
        chk("shade", pix.pix_shade, e.s);
        chk("pix_x", pix.pix_x, e.x);
        chk("pix_y", pix.pix_y, e.y);
        chk("sof", pix.pix_sof, (e.x == 0 && e.y == 0));
        chk("eol", pix.pix_eol, (e.x == HR-1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix.pix_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_valid", pix.pix_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_shade", pix.pix_shade, 0);
    chk("rst_xy", {pix.pix_x, pix.pix_y}, 0);
    chk("rst_sofeol", {pix.pix_sof, pix.pix_eol}, 0);

    send(0, 0, 3'b000, 0, 8'hC0, 1);
    chk("miss_valid", pix.pix_valid, 1);
    chk("miss_sof", pix.pix_sof, 1);
    chk("miss_count", fifo_count, 1);
    pix.pix_ready = 1'b1;
    send(1, 0, 3'b001, 40, E_X40, 1);
    send(1, 0, 3'b001, 2000, E_X2000, 1);
    send(1, 0, 3'b010, 100, E_Y100, 1);
    send(1, 0, 3'b100, 0, 8'h70, 1);
    send(1, 1, 3'b001, 0, 8'h00, 1);
    send(1, 0, 3'b011, 0, 8'h40, 1);
    send(1, 0, 3'b000, 0, 8'h40, 1);
    send(0, 1, 3'b010, 0, 8'h00, 1);
    drain();

    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    mx = 0;
    my = 0;
    for (int i = 0; i < 17; i++) send(0, 0, 3'b000, 0, 8'hC0, 1);
    drain();
    chk("wrap_pos", mx * 16 + my, 1 * 16 + 0);

    pix.pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 0, 3'b100, 0, 8'h70, 1);
    chk("full_count", fifo_count, 4);
    pix.pix_ready = 1'b1;
    send(1, 0, 3'b010, 0, 8'hB0, 1);
    pix.pix_ready = 1'b0;
    chk("fullpop_count", fifo_count, 4);
    chk("fullpop_ovf", overflow, 0);

    reset = 1'b1;
    done  = 1'b1;
    hit   = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    done = 1'b0;
    q.delete();
    mx = 0;
    my = 0;
    chk("midrst_valid", pix.pix_valid, 0);
    chk("midrst_count", fifo_count, 0);

    for (int i = 0; i < 4; i++) send(0, 0, 3'b000, 0, 8'hC0, 1);
    send(0, 0, 3'b000, 0, 8'hC0, 0);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    drain();
    chk("ovf_sticky", overflow, 1);
    send(1, 0, 3'b001, 0, 8'hF0, 1);
    drain();
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
